// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, a pop-data-valid strobe and sticky overflow/underflow flags.
module param_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 4,
  parameter int ALMOST_FULL_LVL  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] pushedValue,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] poppedValue,
  output logic                  pop_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   AF_LVL    = (ADDR_WIDTH+1)'(ALMOST_FULL_LVL);
  localparam logic [ADDR_WIDTH:0]   AE_LVL    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LVL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wrPtr;
  logic [ADDR_WIDTH-1:0] r_rdPtr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_poppedValue;
  logic                  r_popValid;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_almostEmpty;
  logic                  r_almostFull;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_popOk;
  logic                  w_pushOk;
  logic                  w_overflowEvt;
  logic                  w_underflowEvt;
  logic [ADDR_WIDTH:0]   w_countNext;

  // A full FIFO still takes a push when a pop frees a slot on the same edge;
  // an empty FIFO never forwards a same-cycle push to the read side.
  always_comb begin
    w_popOk        = pop & ~r_empty;
    w_pushOk       = push & (~r_full | w_popOk);
    w_overflowEvt  = push & r_full & ~w_popOk;
    w_underflowEvt = pop & r_empty;
    w_countNext    = r_count;
    if (w_pushOk && !w_popOk) begin
      w_countNext = r_count + CNT_ONE;
    end else if (w_popOk && !w_pushOk) begin
      w_countNext = r_count - CNT_ONE;
    end
  end

  // Storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= pushedValue;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_poppedValue <= '0;
      r_popValid    <= 1'b0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_almostFull  <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_popOk) begin
        r_rdPtr       <= r_rdPtr + PTR_ONE;
        r_poppedValue <= r_mem[r_rdPtr];
      end
      r_popValid    <= w_popOk;
      r_count       <= w_countNext;
      r_empty       <= (w_countNext == '0);
      r_full        <= (w_countNext == CNT_DEPTH);
      r_almostEmpty <= (w_countNext <= AE_LVL);
      r_almostFull  <= (w_countNext >= AF_LVL);
    end
  end

  // Error flags are sticky; a new error on the clearing edge keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_overflowEvt) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end
      if (w_underflowEvt) begin
        r_underflow <= 1'b1;
      end else if (clear_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign poppedValue  = r_poppedValue;
  assign pop_valid    = r_popValid;
  assign count        = r_count;
  assign empty        = r_empty;
  assign full         = r_full;
  assign almost_empty = r_almostEmpty;
  assign almost_full  = r_almostFull;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
